// File: rtl/mc10_ctrl_latch_bank_if.sv
// rtl/mc10_ctrl_latch_bank_if.sv - CPU write bus into the MC-10 control latch bank
interface mc10_ctrl_latch_bank_if #(
    parameter int ADDR_W = 2
);
    logic [7:0]        din;
    logic [ADDR_W-1:0] reg_sel;

    modport master (
        output din,
        output reg_sel
    );

    modport slave (
        input din,
        input reg_sel
    );
endinterface

// File: rtl/mc10_ctrl_latch_bank.sv
// rtl/mc10_ctrl_latch_bank.sv - legacy MC-10 video latch plus key-guarded, double-buffered extended registers
module mc10_ctrl_latch_bank #(
    parameter int         DATA_W   = 6,
    parameter int         DATA_LSB = 2,
    parameter int         NREGS    = 4,
    parameter int         ADDR_W   = 2,
    parameter logic [7:0] KEY0     = 8'hA5,
    parameter logic [7:0] KEY1     = 8'h5A
) (
    input  logic                    U8_clock,
    input  logic                    RESET,
    mc10_ctrl_latch_bank_if.slave   bus,
    output logic [DATA_W-1:0]       ctrl0,
    output logic [8*(NREGS-2)-1:0]  ext_active,
    output logic                    unlocked,
    output logic                    pending,
    output logic [7:0]              ign_count
);

    localparam int EXT_N = NREGS - 2;
    localparam int EXT_W = 8 * EXT_N;

    typedef enum logic [1:0] {
        S_LOCKED    = 2'd0,
        S_KEY1_WAIT = 2'd1,
        S_UNLOCKED  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   ctrl0_q, ctrl0_d;
    logic [EXT_W-1:0]    shadow_q, shadow_d;
    logic [EXT_W-1:0]    active_q, active_d;
    logic                pending_q, pending_d;
    logic [7:0]          ign_q, ign_d;

    logic [31:0]         sel_w;
    logic                sel_legacy;
    logic                sel_ext;
    logic                sel_ctrl;
    logic                ign_bump;

    // Widen the select so unmapped addresses (NREGS not a power of two) decode cleanly.
    always_comb begin
        sel_w      = 32'(bus.reg_sel);
        sel_legacy = (sel_w == 32'd0);
        sel_ext    = (sel_w >= 32'd1) && (sel_w <= 32'(NREGS - 2));
        sel_ctrl   = (sel_w == 32'(NREGS - 1));
    end

    always_ff @(posedge U8_clock or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_LOCKED;
            ctrl0_q   <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            ign_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            ctrl0_q   <= ctrl0_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            ign_q     <= ign_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ctrl0_d   = ctrl0_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        ign_d     = ign_q;
        ign_bump  = 1'b0;

        if (sel_legacy) begin
            // The legacy latch is always writable; it also aborts a half-entered key sequence.
            ctrl0_d = bus.din[DATA_LSB+DATA_W-1:DATA_LSB];
            if (state_q == S_KEY1_WAIT) begin
                state_d = S_LOCKED;
            end
        end else if (sel_ext) begin
            unique case (state_q)
                S_UNLOCKED: begin
                    for (int k = 1; k <= EXT_N; k++) begin
                        if (sel_w == 32'(k)) begin
                            shadow_d[8*(k-1) +: 8] = bus.din;
                        end
                    end
                    pending_d = 1'b1;
                end
                S_KEY1_WAIT: begin
                    state_d  = S_LOCKED;
                    ign_bump = 1'b1;
                end
                default: begin
                    ign_bump = 1'b1;
                end
            endcase
        end else if (sel_ctrl) begin
            unique case (state_q)
                S_LOCKED: begin
                    if (bus.din == KEY0) begin
                        state_d = S_KEY1_WAIT;
                    end
                end
                S_KEY1_WAIT: begin
                    if (bus.din == KEY1) begin
                        state_d = S_UNLOCKED;
                    end else if (bus.din != KEY0) begin
                        state_d = S_LOCKED;
                    end
                end
                S_UNLOCKED: begin
                    if (bus.din[0]) begin
                        active_d  = shadow_q;
                        pending_d = 1'b0;
                    end
                    if (bus.din[7]) begin
                        state_d = S_LOCKED;
                    end
                end
                default: begin
                    state_d = S_LOCKED;
                end
            endcase
        end

        if (ign_bump && (ign_q != 8'hFF)) begin
            ign_d = ign_q + 8'd1;
        end
    end

    always_comb begin
        ctrl0      = ctrl0_q;
        ext_active = active_q;
        unlocked   = (state_q == S_UNLOCKED);
        pending    = pending_q;
        ign_count  = ign_q;
    end

endmodule

// File: tb/tb_mc10_ctrl_latch_bank.sv
// tb/tb_mc10_ctrl_latch_bank.sv - scoreboard bench for mc10_ctrl_latch_bank
module tb_mc10_ctrl_latch_bank;

    logic        U8_clock;
    logic        RESET;
    logic [5:0]  ctrl0;
    logic [15:0] ext_active;
    logic        unlocked;
    logic        pending;
    logic [7:0]  ign_count;

    mc10_ctrl_latch_bank_if #(.ADDR_W(2)) bus ();

    mc10_ctrl_latch_bank #(
        .DATA_W   (6),
        .DATA_LSB (2),
        .NREGS    (4),
        .ADDR_W   (2),
        .KEY0     (8'hA5),
        .KEY1     (8'h5A)
    ) dut (
        .U8_clock   (U8_clock),
        .RESET      (RESET),
        .bus        (bus.slave),
        .ctrl0      (ctrl0),
        .ext_active (ext_active),
        .unlocked   (unlocked),
        .pending    (pending),
        .ign_count  (ign_count)
    );

    typedef struct {
        logic [5:0]  ctrl0;
        logic [15:0] ext;
        logic        unl;
        logic        pend;
        logic [7:0]  ign;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 = LOCKED, 1 = KEY1_WAIT, 2 = UNLOCKED
    int          m_state;
    logic [5:0]  m_ctrl0;
    logic [15:0] m_shadow;
    logic [15:0] m_ext;
    logic        m_pend;
    logic [7:0]  m_ign;

    initial begin
        U8_clock = 1'b0;
        forever #5 U8_clock = ~U8_clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired: time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_ctrl0  = 6'd0;
        m_shadow = 16'd0;
        m_ext    = 16'd0;
        m_pend   = 1'b0;
        m_ign    = 8'd0;
    endtask

    task automatic model_write(input logic [1:0] sel, input logic [7:0] d);
        exp_t e;
        if (sel == 2'd0) begin
            m_ctrl0 = d[7:2];
            if (m_state == 1) m_state = 0;
        end else if (sel == 2'd3) begin
            if (m_state == 0) begin
                if (d == 8'hA5) m_state = 1;
            end else if (m_state == 1) begin
                if (d == 8'h5A) m_state = 2;
                else if (d != 8'hA5) m_state = 0;
            end else begin
                if (d[0]) begin
                    m_ext  = m_shadow;
                    m_pend = 1'b0;
                end
                if (d[7]) m_state = 0;
            end
        end else begin
            if (m_state == 2) begin
                if (sel == 2'd1) m_shadow[7:0]  = d;
                else             m_shadow[15:8] = d;
                m_pend = 1'b1;
            end else begin
                m_state = 0;
                if (m_ign != 8'hFF) m_ign = m_ign + 8'd1;
            end
        end
        e.ctrl0 = m_ctrl0;
        e.ext   = m_ext;
        e.unl   = (m_state == 2);
        e.pend  = m_pend;
        e.ign   = m_ign;
        sb_q.push_back(e);
    endtask

    // Each rising edge consumes exactly one queued write; outputs sampled 1 ns later.
    initial begin
        exp_t e;
        forever begin
            @(posedge U8_clock);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("sb_ctrl0",    32'(ctrl0),      32'(e.ctrl0));
                check_eq("sb_ext",      32'(ext_active), 32'(e.ext));
                check_eq("sb_unlocked", 32'(unlocked),   32'(e.unl));
                check_eq("sb_pending",  32'(pending),    32'(e.pend));
                check_eq("sb_ign",      32'(ign_count),  32'(e.ign));
            end
        end
    end

    task automatic wr(input logic [1:0] sel, input logic [7:0] d);
        @(negedge U8_clock);
        bus.reg_sel = sel;
        bus.din     = d;
        model_write(sel, d);
    endtask

    task automatic settle();
        @(posedge U8_clock);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ctrl0"},    32'(ctrl0),      32'd0);
        check_eq({tag, "_ext"},      32'(ext_active), 32'd0);
        check_eq({tag, "_unlocked"}, 32'(unlocked),   32'd0);
        check_eq({tag, "_pending"},  32'(pending),    32'd0);
        check_eq({tag, "_ign"},      32'(ign_count),  32'd0);
    endtask

    // Asserts RESET between edges so the clear must be asynchronous to be seen.
    task automatic pulse_reset(input string tag);
        @(negedge U8_clock);
        #2;
        RESET = 1'b1;
        model_reset();
        #1;
        check_reset_outputs(tag);
        repeat (2) @(negedge U8_clock);
        bus.reg_sel = 2'd0;
        bus.din     = 8'h00;
        RESET       = 1'b0;
        model_write(2'd0, 8'h00);
    endtask

    task automatic unlock();
        wr(2'd3, 8'hA5);
        wr(2'd3, 8'h5A);
    endtask

    initial begin
        logic [7:0] pick [7];
        logic [7:0] d;
        pick[0] = 8'hA5; pick[1] = 8'h5A; pick[2] = 8'h01; pick[3] = 8'h80;
        pick[4] = 8'h81; pick[5] = 8'h00; pick[6] = 8'h3C;

        RESET       = 1'b0;
        bus.din     = 8'h00;
        bus.reg_sel = 2'd0;
        model_reset();
        pulse_reset("rst0");

        // Legacy latch
        wr(2'd0, 8'hFC);
        settle();
        check_eq("t1_ctrl0", 32'(ctrl0), 32'h3F);
        check_eq("t1_ext", 32'(ext_active), 32'h0);
        check_eq("t1_unlocked", 32'(unlocked), 32'h0);

        // Locked extended write is counted
        wr(2'd1, 8'h11);
        settle();
        check_eq("t2_ign1", 32'(ign_count), 32'd1);
        check_eq("t2_ext", 32'(ext_active), 32'h0);

        // Extended write during KEY1_WAIT is counted and relocks
        wr(2'd3, 8'hA5);
        wr(2'd2, 8'h44);
        wr(2'd3, 8'h5A);
        settle();
        check_eq("t2_kw_ign", 32'(ign_count), 32'd2);
        check_eq("t2_kw_locked", 32'(unlocked), 32'd0);

        for (int i = 0; i < 300; i++) wr(2'd1, 8'h11);
        settle();
        check_eq("t2_ign_sat", 32'(ign_count), 32'd255);

        // Unlock, shadow write, commit
        unlock();
        settle();
        check_eq("t3_unlocked", 32'(unlocked), 32'd1);
        wr(2'd1, 8'h3C);
        settle();
        check_eq("t3_pending", 32'(pending), 32'd1);
        check_eq("t3_ext_before", 32'(ext_active[7:0]), 32'h00);
        wr(2'd3, 8'h01);
        settle();
        check_eq("t3_ext_commit", 32'(ext_active[7:0]), 32'h3C);
        check_eq("t3_pending_clr", 32'(pending), 32'd0);
        wr(2'd3, 8'h01);
        settle();
        check_eq("t3_empty_commit", 32'(ext_active), 32'h003C);

        // Legacy write aborts key sequence; repeated KEY0 holds KEY1_WAIT
        wr(2'd3, 8'h80);
        wr(2'd3, 8'hA5);
        wr(2'd0, 8'h00);
        wr(2'd3, 8'h5A);
        settle();
        check_eq("t4_aborted", 32'(unlocked), 32'd0);
        wr(2'd3, 8'hA5);
        wr(2'd3, 8'hA5);
        wr(2'd3, 8'h5A);
        settle();
        check_eq("t4_rekey", 32'(unlocked), 32'd1);

        // Commit and relock on one edge
        wr(2'd2, 8'h77);
        wr(2'd3, 8'h81);
        settle();
        check_eq("t5_ext_hi", 32'(ext_active[15:8]), 32'h77);
        check_eq("t5_unlocked", 32'(unlocked), 32'd0);
        check_eq("t5_pending", 32'(pending), 32'd0);

        // Mixed traffic against the model
        for (int i = 0; i < 200; i++) begin
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pick[$urandom_range(0, 6)];
            wr(2'($urandom_range(0, 3)), d);
        end
        settle();

        // Reset mid-sequence discards shadow and active
        unlock();
        wr(2'd1, 8'h55);
        settle();
        check_eq("t6_pending", 32'(pending), 32'd1);
        pulse_reset("t6_rst");
        unlock();
        wr(2'd3, 8'h01);
        settle();
        check_eq("t6_shadow_gone", 32'(ext_active), 32'h0);

        settle();
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
